// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_pkg
// Purpose  : Shared widths, constants and types for the instruction-fetch
//            controller (address/instruction bus widths, zero word, reset PC,
//            controller state and per-edge action encodings).
// Revision : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

  // Instruction address bus and instruction bus widths
  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_W-1:0]      ZERO_WORD     = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] RESET_PC_DFLT = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] PC_STEP       = 32'd4;

  // FS_OFF: ROM not yet enabled after reset; FS_RUN: fetching
  typedef enum logic [0:0] {
    FS_OFF = 1'b0,
    FS_RUN = 1'b1
  } fetch_state_e;

  // What the controller does at the coming rising edge
  typedef enum logic [2:0] {
    ACT_RESET  = 3'd0,
    ACT_FLUSH  = 3'd1,
    ACT_START  = 3'd2,
    ACT_STALL  = 3'd3,
    ACT_BRANCH = 3'd4,
    ACT_SEQ    = 3'd5
  } fetch_act_e;

  // Resolve the per-edge priority: reset, flush, start-up, stall, branch,
  // sequential. A branch raised under stall is ignored; the producer keeps
  // it asserted until the stall clears.
  function automatic fetch_act_e fetch_decode(
    input logic rst,
    input logic flush,
    input logic running,
    input logic stall,
    input logic branch
  );
    fetch_act_e act;
    if (rst)           act = ACT_RESET;
    else if (flush)    act = ACT_FLUSH;
    else if (!running) act = ACT_START;
    else if (stall)    act = ACT_STALL;
    else if (branch)   act = ACT_BRANCH;
    else               act = ACT_SEQ;
    return act;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_hold_buf
// Purpose  : One-entry hold buffer for the synchronous instruction ROM. On the
//            first stalled edge it captures the instruction being presented so
//            the ROM may keep running; the output mux then serves the held
//            word until the stall is released or the buffer is cleared.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_hold_buf
  import fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              stall,
  input  logic              clear,
  input  logic [INST_W-1:0] inst,
  output logic [INST_W-1:0] out_inst
);

  logic [INST_W-1:0] hold_inst_q;
  logic [INST_W-1:0] hold_inst_d;
  logic              hold_valid_q;
  logic              hold_valid_d;

  // Next-state: clear wins, first stalled edge captures, release empties
  always_comb begin
    hold_inst_d  = hold_inst_q;
    hold_valid_d = hold_valid_q;
    if (clear) begin
      hold_inst_d  = ZERO_WORD;
      hold_valid_d = 1'b0;
    end else if (stall) begin
      if (!hold_valid_q) begin
        hold_inst_d  = inst;
        hold_valid_d = 1'b1;
      end
    end else begin
      hold_valid_d = 1'b0;
    end
  end

  // Hold register; clear carries the synchronous reset
  always_ff @(posedge clk) begin
    hold_inst_q  <= hold_inst_d;
    hold_valid_q <= hold_valid_d;
  end

  assign out_inst = hold_valid_q ? hold_inst_q : inst;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : MIPS32 instruction-fetch controller. Owns the PC, drives the
//            instruction ROM enable/address, and pairs each registered ROM
//            word with its fetch address for decode. Handles stall (via a
//            one-entry hold buffer), delayed-branch redirect and exception
//            flush.
// Options  : FETCH_ADEL_CHECK_EN - flag misaligned fetch addresses on id_adel
//            and present a nop in their place.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DFLT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag,
  input  logic [INST_ADDR_W-1:0] branch_target,
  output logic                   ce,
  output logic [INST_ADDR_W-1:0] pc,
  input  logic [INST_W-1:0]      inst,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_valid,
  output logic                   id_adel
);

  fetch_state_e           state_q;
  fetch_state_e           state_d;
  logic [INST_ADDR_W-1:0] pc_q;
  logic [INST_ADDR_W-1:0] pc_d;
  logic [INST_ADDR_W-1:0] fetch_pc_q;
  logic [INST_ADDR_W-1:0] fetch_pc_d;
  logic                   valid_q;
  logic                   valid_d;
  fetch_act_e             act;
  logic                   buf_clear;
  logic [INST_W-1:0]      buf_inst;

  // Next-state for PC, in-flight address, valid and start-up state
  always_comb begin
    act        = fetch_decode(rst, flush, (state_q == FS_RUN), stall, branch_flag);
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    valid_d    = valid_q;
    unique case (act)
      ACT_RESET: begin
        state_d    = FS_OFF;
        pc_d       = RESET_PC;
        fetch_pc_d = RESET_PC;
        valid_d    = 1'b0;
      end
      ACT_FLUSH: begin
        pc_d       = new_pc;
        fetch_pc_d = pc_q;
        valid_d    = 1'b0;
      end
      ACT_START: begin
        state_d = FS_RUN;
        valid_d = 1'b0;
      end
      ACT_STALL: begin
        // Everything holds; the ROM re-reads pc while the hold buffer
        // keeps the presented word.
      end
      ACT_BRANCH: begin
        // The delay slot is consumed at this edge; the in-flight pc
        // fetch returns next cycle as a bubble.
        pc_d       = branch_target;
        fetch_pc_d = pc_q;
        valid_d    = 1'b0;
      end
      ACT_SEQ: begin
        pc_d       = pc_q + PC_STEP;
        fetch_pc_d = pc_q;
        valid_d    = 1'b1;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_OFF;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
    end
  end

  // Any redirect or reset makes a held instruction stale
  assign buf_clear = rst | flush | (act == ACT_BRANCH);

  fetch_hold_buf u_hold_buf (
    .clk      (clk),
    .stall    (stall),
    .clear    (buf_clear),
    .inst     (inst),
    .out_inst (buf_inst)
  );

  assign ce       = (state_q == FS_RUN);
  assign pc       = pc_q;
  assign id_pc    = fetch_pc_q;
  assign id_valid = valid_q;

`ifdef FETCH_ADEL_CHECK_EN
  logic adel;
  assign adel    = valid_q & (fetch_pc_q[1:0] != 2'b00);
  assign id_adel = adel;
  assign id_inst = adel ? ZERO_WORD : buf_inst;
`else
  assign id_adel = 1'b0;
  assign id_inst = buf_inst;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Directed self-checking bench for fetch_ctrl: reset/start-up,
//            free-run, stall hold, delayed branch, branch under stall, flush
//            during stall, PC wrap-around, misaligned branch target.
// Options  : FETCH_ADEL_CHECK_EN - expects id_adel/nop on misaligned fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        ce;
  logic [31:0] pc;
  logic [31:0] inst = 32'h0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_adel;

  int n_checks = 0;
  int n_errors = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .ce            (ce),
    .pc            (pc),
    .inst          (inst),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid),
    .id_adel       (id_adel)
  );

  always #5 clk = ~clk;

  // ROM contents as a function of the byte address
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Synchronous ROM
  always @(posedge clk) begin
    if (ce) inst <= rom(pc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bubble(input string tag);
    check_eq({tag, ".valid"}, {31'b0, id_valid}, 32'd0);
  endtask

  task automatic expect_id(input string tag, input logic [31:0] a);
    logic        adel;
    logic [31:0] exp_inst;
`ifdef FETCH_ADEL_CHECK_EN
    adel = (a[1:0] != 2'b00);
`else
    adel = 1'b0;
`endif
    exp_inst = adel ? 32'h0 : rom(a);
    check_eq({tag, ".valid"}, {31'b0, id_valid}, 32'd1);
    check_eq({tag, ".pc"},    id_pc,             a);
    check_eq({tag, ".inst"},  id_inst,           exp_inst);
    check_eq({tag, ".adel"},  {31'b0, id_adel},  {31'b0, adel});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; new_pc = 32'h0;
    branch_flag = 1'b0; branch_target = 32'h0;

    // Reset
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst.ce", {31'b0, ce}, 32'd0);
      check_eq("rst.pc", pc, 32'h0);
      expect_bubble("rst");
    end

    // Start-up and free-run
    rst = 1'b0;
    tick();
    check_eq("start.ce", {31'b0, ce}, 32'd1);
    expect_bubble("start");
    tick(); expect_id("run0", 32'h0);
    tick(); expect_id("run4", 32'h4);
    tick(); expect_id("run8", 32'h8);

    // Stall three cycles while presenting 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_id("stall8", 32'h8);
    end
    stall = 1'b0;
    tick(); expect_id("rel12", 32'hC);

    // Delayed branch: 0x14 is the delay slot
    tick(); expect_id("br10", 32'h10);
    tick(); expect_id("br14", 32'h14);
    branch_flag = 1'b1; branch_target = 32'h40;
    tick(); expect_bubble("br.bub");
    branch_flag = 1'b0;
    tick(); expect_id("br40", 32'h40);
    tick(); expect_id("br44", 32'h44);

    // Branch held under stall is taken only on release
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h100;
    tick(); expect_id("brst44", 32'h44);
    stall = 1'b0;
    tick(); expect_bubble("brst.bub");
    branch_flag = 1'b0;
    tick(); expect_id("brst100", 32'h100);
    tick(); expect_id("brst104", 32'h104);

    // Flush during stall
    stall = 1'b1;
    tick(); expect_id("fl.hold", 32'h104);
    flush = 1'b1; new_pc = 32'h180;
    tick(); expect_bubble("fl.bub");
    flush = 1'b0; stall = 1'b0;
    tick(); expect_id("fl180", 32'h180);
    tick(); expect_id("fl184", 32'h184);

    // Wrap-around
    flush = 1'b1; new_pc = 32'hFFFF_FFF8;
    tick(); expect_bubble("wr.bub");
    flush = 1'b0;
    tick(); expect_id("wrF8", 32'hFFFF_FFF8);
    tick(); expect_id("wrFC", 32'hFFFF_FFFC);
    tick(); expect_id("wr0",  32'h0);
    tick(); expect_id("wr4",  32'h4);

    // Misaligned branch target
    branch_flag = 1'b1; branch_target = 32'h42;
    tick(); expect_bubble("ad.bub");
    branch_flag = 1'b0;
    tick(); expect_id("ad42", 32'h42);
    tick(); expect_id("ad46", 32'h46);

    // Reset mid-stall clears the hold buffer
    stall = 1'b1;
    tick(); expect_id("rs.hold", 32'h46);
    rst = 1'b1;
    tick();
    check_eq("rs.ce", {31'b0, ce}, 32'd0);
    check_eq("rs.pc", pc, 32'h0);
    expect_bubble("rs");
    rst = 1'b0; stall = 1'b0;
    tick(); expect_bubble("rs.start");
    tick(); expect_id("rs0", 32'h0);
    tick(); expect_id("rs4", 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller of the MIPS32 pipeline, directly upstream of the instruction ROM: owns the program counter, drives the ROM's `ce`/`pc`, and pairs each registered ROM output with its fetch address for decode. Handles pipeline stall, which requires a one-entry hold buffer because the ROM read is synchronous; branch redirect with the MIPS delay slot preserved; and exception flush.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset and while `rst` is high.
- `clk` in 1: single clock; all registers update on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: decode cannot accept; the current `id_*` must be held.
- `flush` in 1: exception redirect to `new_pc`; overrides everything except `rst`.
- `new_pc` in 32: exception target.
- `branch_flag` in 1: taken branch/jump resolved in decode.
- `branch_target` in 32: branch destination.
- `ce` out 1: ROM enable.
- `pc` out 32: ROM address.
- `inst` in 32: ROM data; valid the cycle after `ce`/`pc` are sampled.
- `id_pc` out 32: address of the presented instruction.
- `id_inst` out 32: presented instruction.
- `id_valid` out 1: `id_pc`/`id_inst` are meaningful.
- `id_adel` out 1: misaligned fetch address flag (see Configuration).

## Operation
- Registers: `ce`, `pc`, `fetch_pc` (address the ROM is returning), `valid`, `hold_inst`, `hold_valid`.
- `id_pc = fetch_pc`; `id_inst = hold_valid ? hold_inst : inst`; `id_valid = valid`.
- An instruction is consumed at a rising edge where `id_valid=1` and `stall=0`.
- Priority per edge: `rst` > `flush` > `stall` > `branch_flag` > sequential.
- rst: `ce=0`, `pc=RESET_PC`, `fetch_pc=RESET_PC`, `valid=0`, `hold_valid=0`, `hold_inst=0`.
- Start-up, `ce=0` and no `rst`: `ce<=1`; `pc` unchanged; `valid<=0`.
- flush: `pc<=new_pc`, `fetch_pc<=pc`, `valid<=0`, `hold_valid<=0`.
- stall:
  - `pc` and `fetch_pc` hold; `ce` remains 1.
  - If `hold_valid=0`, capture `hold_inst<=inst` and set `hold_valid<=1`.
  - `valid` holds.
- branch_flag (no stall):
  - `pc<=branch_target`, `fetch_pc<=pc`, `valid<=0`, `hold_valid<=0`.
  - The in-flight `pc` fetch is squashed.
  - The delay-slot instruction is the one presented during the branch cycle; it is consumed normally.
- Sequential (no stall): `pc<=pc+4` (wraps modulo 2^32), `fetch_pc<=pc`, `valid<=1`, `hold_valid<=0`.
- `branch_flag` asserted together with `stall` is ignored. The producer keeps it asserted until a non-stall cycle.

## Timing
- Fetch latency: address on `pc` at edge N, instruction on `id_inst` after edge N, paired with `fetch_pc`.
- After `rst` falls: `ce=1` after edge 1; first `id_valid=1` (`id_pc=RESET_PC`) after edge 2.
- Taken branch: exactly one bubble (`id_valid=0`) after the delay slot; the target is presented one cycle later.
- Flush: one bubble, then `new_pc` is presented.
- Stall of any length: `id_pc`/`id_inst` stable throughout. The cycle after release presents `pc` (the next sequential address) with no bubble and no duplicate.
- `rst` mid-stall or mid-branch: all state is cleared; `hold_valid=0` next cycle.

## Configuration
- `FETCH_ADEL_CHECK_EN` defined:
  - `id_adel = valid & (fetch_pc[1:0] != 0)`.
  - While `id_adel=1`, `id_inst` is forced to 32'h0 (nop).
  - Sequencing is unaffected; decode raises the AdEL exception.
- `FETCH_ADEL_CHECK_EN` undefined: `id_adel` is tied 0 and `id_inst` is never forced.

## Structure
- Shared `define.v` supplies the widths and constants used here: `InstAddrBus`, `InstBus`, `ZeroWord`, and a `ResetPC` constant used as the `RESET_PC` default.
- One sub-module, `fetch_hold_buf`: `hold_inst`/`hold_valid` register plus the output mux. Inputs are `stall`, `clear` (`rst|flush|branch`), and `inst`.

## Test plan
- Reset then free-run, `RESET_PC=0`: `id_valid` rises after the 2nd edge; `id_pc` runs 0, 4, 8, 12 in consecutive cycles; `ce=0` during reset.
- Stall for 3 cycles while presenting `id_pc=8`: `id_pc=8` and `id_inst=rom[2]` are held for 3 cycles; after release, `id_pc=12` with `id_inst=rom[3]`, no duplicate or skip.
- Branch at `id_pc=0x10` to `0x40`:
  - `0x14` (delay slot) is presented and consumed.
  - Next cycle `id_valid=0`.
  - Then `0x40`, `0x44`.
- `flush` with `new_pc=0x180` during a stall: the hold buffer is discarded; `id_valid=0` for one cycle; then `id_pc=0x180`.
- Wrap-around: `pc=32'hFFFF_FFFC` advances to `32'h0` with no error.
- `FETCH_ADEL_CHECK_EN` with `branch_target=0x42`: `id_adel=1` and `id_inst=0` when `id_pc=0x42`. Without the macro, `id_adel` stays 0.
